// File: rtl/mpy_arbiter_if.sv
// Bundle between the multiply clients, the shared signed multiplier core and mpy_arbiter.
// slave is the arbiter's view; master is the clients/multiplier side.
interface mpy_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NA   = 32,
  parameter int NB   = 32,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req;
  logic [NREQ*NA-1:0] a;
  logic [NREQ*NB-1:0] b;
  logic [NREQ-1:0]    grant;
  logic               mpy_ce;
  logic [NA-1:0]      mpy_a;
  logic [NB-1:0]      mpy_b;
  logic               mpy_aux;
  logic [NA+NB-1:0]   mpy_p;
  logic               mpy_aux_ret;
  logic               valid;
  logic [IDW-1:0]     id;
  logic [NA+NB-1:0]   p;
  logic               err;

  modport slave (
    input  req, a, b, mpy_p, mpy_aux_ret,
    output grant, mpy_ce, mpy_a, mpy_b, mpy_aux, valid, id, p, err
  );

  modport master (
    output req, a, b, mpy_p, mpy_aux_ret,
    input  grant, mpy_ce, mpy_a, mpy_b, mpy_aux, valid, id, p, err
  );
endinterface

// File: rtl/mpy_arbiter.sv
// Shares one pipelined signed multiplier between NREQ requesters and tags each product with its owner.
// Define MPYARB_FIXPRI_EN for lowest-index-wins arbitration instead of round-robin.
module mpy_arbiter #(
  parameter int NREQ = 4,
  parameter int NA   = 32,
  parameter int NB   = 32,
  parameter int LAT  = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic          i_clk,
  input logic          i_reset,
  mpy_arbiter_if.slave bus
);

  logic [NREQ-1:0]  grant_c;
  logic [IDW-1:0]   grant_id;
  logic [NA-1:0]    sel_a;
  logic [NB-1:0]    sel_b;
  logic             accept;

  logic [NA-1:0]    mpy_a_q;
  logic [NB-1:0]    mpy_b_q;
  logic             mpy_aux_q;
  logic [IDW-1:0]   launch_id;
  logic [LAT-1:0]   sh_v;
  logic [IDW-1:0]   sh_id [LAT];
  logic             valid_q;
  logic [IDW-1:0]   id_q;
  logic [NA+NB-1:0] p_q;
  logic             err_q;

`ifndef MPYARB_FIXPRI_EN
  logic [IDW-1:0]   last;
  int               idx;
`endif

  // Candidates are scanned from lowest to highest priority so the winner is the last one written.
  always_comb begin
    grant_c  = '0;
    grant_id = '0;
    sel_a    = '0;
    sel_b    = '0;
`ifdef MPYARB_FIXPRI_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        grant_c    = '0;
        grant_c[i] = 1'b1;
        grant_id   = IDW'(i);
        sel_a      = bus.a[i*NA +: NA];
        sel_b      = bus.b[i*NB +: NB];
      end
    end
`else
    idx = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) begin
        grant_c      = '0;
        grant_c[idx] = 1'b1;
        grant_id     = IDW'(idx);
        sel_a        = bus.a[idx*NA +: NA];
        sel_b        = bus.b[idx*NB +: NB];
      end
    end
`endif
    if (i_reset) grant_c = '0;
  end

  assign accept = |grant_c;

  // The shadow pipe is fed from the launch registers so its tail lines up with the multiplier output.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mpy_a_q   <= '0;
      mpy_b_q   <= '0;
      mpy_aux_q <= 1'b0;
      launch_id <= '0;
      sh_v      <= '0;
      for (int i = 0; i < LAT; i++) sh_id[i] <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      p_q       <= '0;
      err_q     <= 1'b0;
`ifndef MPYARB_FIXPRI_EN
      last      <= IDW'(NREQ - 1);
`endif
    end else begin
      mpy_aux_q <= accept;
      if (accept) begin
        mpy_a_q   <= sel_a;
        mpy_b_q   <= sel_b;
        launch_id <= grant_id;
`ifndef MPYARB_FIXPRI_EN
        last      <= grant_id;
`endif
      end
      sh_v[0]  <= mpy_aux_q;
      sh_id[0] <= launch_id;
      for (int i = 1; i < LAT; i++) begin
        sh_v[i]  <= sh_v[i-1];
        sh_id[i] <= sh_id[i-1];
      end
      valid_q <= bus.mpy_aux_ret;
      if (bus.mpy_aux_ret) begin
        p_q  <= bus.mpy_p;
        id_q <= sh_id[LAT-1];
      end
      if (bus.mpy_aux_ret != sh_v[LAT-1]) err_q <= 1'b1;
    end
  end

  assign bus.grant   = grant_c;
  assign bus.mpy_ce  = ~i_reset;
  assign bus.mpy_a   = mpy_a_q;
  assign bus.mpy_b   = mpy_b_q;
  assign bus.mpy_aux = mpy_aux_q;
  assign bus.valid   = valid_q;
  assign bus.id      = id_q;
  assign bus.p       = p_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mpy_arbiter.sv
// Bench for mpy_arbiter: directed scenarios plus random traffic, scored against a queue-based model
// and a behavioural LAT-stage multiplier.
module tb_mpy_arbiter;
  localparam int NREQ = 4;
  localparam int NA   = 32;
  localparam int NB   = 32;
  localparam int LAT  = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic inject = 1'b0;
  always #5 clk = ~clk;

  mpy_arbiter_if #(.NREQ(NREQ), .NA(NA), .NB(NB), .IDW(IDW)) bus ();

  mpy_arbiter #(.NREQ(NREQ), .NA(NA), .NB(NB), .LAT(LAT), .IDW(IDW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // behavioural multiplier: LAT clocks from launch registers to result, reset with the arbiter
  logic [LAT-1:0]          mv;
  logic signed [NA+NB-1:0] mp [LAT];
  always @(posedge clk) begin
    if (rst) begin
      mv <= '0;
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else begin
      mv    <= {mv[LAT-2:0], bus.mpy_aux};
      mp[0] <= 64'($signed(bus.mpy_a)) * 64'($signed(bus.mpy_b));
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign bus.mpy_aux_ret = mv[LAT-1] | inject;
  assign bus.mpy_p       = mp[LAT-1];

  typedef struct {
    int          due;
    int          id;
    logic [63:0] p;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_m = NREQ - 1;
  bit          err_m = 1'b0;
  bit          sb_on = 1'b0;
  logic        pend [NREQ];
  logic [NA-1:0] opa [NREQ];
  logic [NB-1:0] opb [NREQ];
  exp_t        q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < NREQ; k++) begin
      bus.req[k]          = pend[k];
      bus.a[k*NA +: NA]   = opa[k];
      bus.b[k*NB +: NB]   = opb[k];
    end
  endtask

  task automatic set_all(input logic v);
    for (int k = 0; k < NREQ; k++) pend[k] = v;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // one clock: score registered outputs, present requests, check the grant, update the model
  task automatic step();
    int          gk;
    bit          ev;
    logic [3:0]  eg;
    exp_t        e;
    @(negedge clk);
    if (sb_on) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("valid", bus.valid, ev);
      if (ev) begin
        chk("id", bus.id, q[0].id);
        chk("product", bus.p, q[0].p);
        void'(q.pop_front());
      end
      chk("err", bus.err, err_m);
      chk("mpy_ce", bus.mpy_ce, 1);
    end
    apply_inputs();
    #1;
    gk = -1;
`ifdef MPYARB_FIXPRI_EN
    for (int k = 0; k < NREQ && gk < 0; k++) if (pend[k]) gk = k;
`else
    for (int off = 1; off <= NREQ && gk < 0; off++)
      if (pend[(last_m + off) % NREQ]) gk = (last_m + off) % NREQ;
`endif
    eg = '0;
    if (gk >= 0) eg[gk] = 1'b1;
    chk("grant", bus.grant, eg);
    if (gk >= 0) begin
      e.due = cyc + LAT + 2;
      e.id  = gk;
      e.p   = 64'($signed(opa[gk])) * 64'($signed(opb[gk]));
      q.push_back(e);
      pend[gk] = 1'b0;
      last_m   = gk;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    set_all(1'b1);
    apply_inputs();
    #1;
    chk("grant_in_reset", bus.grant, 0);
    chk("ce_in_reset", bus.mpy_ce, 0);
    repeat (n) @(negedge clk);
    chk("rst_valid", bus.valid, 0);
    chk("rst_p", bus.p, 0);
    chk("rst_id", bus.id, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mpy_a", bus.mpy_a, 0);
    chk("rst_mpy_b", bus.mpy_b, 0);
    chk("rst_mpy_aux", bus.mpy_aux, 0);
    rst = 1'b0;
    set_all(1'b0);
    apply_inputs();
    q.delete();
    last_m = NREQ - 1;
    err_m  = 1'b0;
    cyc    = 0;
  endtask

  initial begin
    int   n;
    int   first_v;
    int   last_v;
    longint v;

    rst = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      pend[k] = 1'b0;
      opa[k]  = '0;
      opb[k]  = '0;
    end
    apply_inputs();
    sb_on = 1'b1;

    // single request
    do_reset(2);
    pend[0] = 1'b1; opa[0] = -32'sd3; opb[0] = 32'sd7;
    step();
    chk("single_grant", bus.grant, 4'b0001);
    repeat (LAT + 2) step();
    chk("single_valid", bus.valid, 1);
    chk("single_id", bus.id, 0);
    chk("single_p", bus.p, -64'sd21);
    step();
    chk("hold_valid", bus.valid, 0);
    chk("hold_p", bus.p, -64'sd21);

    // all four requesting every clock
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        pend[k] = 1'b1; opa[k] = 32'(k + 1); opb[k] = -32'sd2;
      end
      step();
`ifdef MPYARB_FIXPRI_EN
      chk("rot_grant", bus.grant, 4'b0001);
`else
      chk("rot_grant", bus.grant, 4'b0001 << (i % 4));
`endif
    end
    set_all(1'b0);
    n = 0; first_v = -1; last_v = -1;
    for (int j = 0; j < LAT + 10; j++) begin
      step();
      if (bus.valid) begin
`ifdef MPYARB_FIXPRI_EN
        v = -64'sd2;
`else
        v = -2 * longint'(n % 4 + 1);
`endif
        chk("rot_p", bus.p, v);
        if (first_v < 0) first_v = j;
        last_v = j;
        n++;
      end
    end
    chk("rot_count", n, 8);
    chk("rot_no_gap", last_v - first_v, 7);

    // operand extremes
    do_reset(1);
    pend[0] = 1'b1; opa[0] = 32'h8000_0000; opb[0] = 32'h8000_0000;
    step();
    repeat (LAT + 2) step();
    chk("ext_min_min", bus.p, 64'h4000_0000_0000_0000);
    pend[2] = 1'b1; opa[2] = 32'hFFFF_FFFF; opb[2] = 32'd1;
    step();
    repeat (LAT + 2) step();
    chk("ext_neg1", bus.p, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ext_neg1_id", bus.id, 2);

    // reset with products in flight
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        pend[k] = 1'b1; opa[k] = $urandom; opb[k] = $urandom;
      end
      step();
    end
    set_all(1'b0);
    repeat (3) step();
    do_reset(2);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("postrst_valid", bus.valid, 0);
    end
    chk("postrst_err", bus.err, 0);
    set_all(1'b1);
    step();
    chk("postrst_grant", bus.grant, 4'b0001);
    set_all(1'b0);
    repeat (LAT + 3) step();

    // requesters 1 and 3 held
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      pend[1] = 1'b1; pend[3] = 1'b1;
      opa[1] = 32'd5; opb[1] = 32'd6; opa[3] = -32'sd9; opb[3] = 32'd4;
      step();
`ifdef MPYARB_FIXPRI_EN
      chk("pair_grant", bus.grant, 4'b0010);
`else
      chk("pair_grant", bus.grant, (i % 2 == 0) ? 4'b0010 : 4'b1000);
`endif
    end
    set_all(1'b0);
    repeat (LAT + 3) step();

    // spurious aux with an empty shadow pipe
    do_reset(1);
    sb_on = 1'b0;
    repeat (3) step();
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("spur_err", bus.err, 1);
    repeat (3) begin
      @(negedge clk);
      chk("spur_sticky", bus.err, 1);
    end
    do_reset(1);
    sb_on = 1'b1;

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(2) == 0) begin
            pend[k] = 1'b1;
            opa[k]  = rnd_op();
            opb[k]  = rnd_op();
          end
        end else if ($urandom_range(15) == 0) begin
          pend[k] = 1'b0;
        end
      end
      step();
    end
    set_all(1'b0);
    repeat (LAT + 3) step();
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
